// File: rtl/mem_map_seq.sv
// Clocked memory map sequencer: registered boot/bank/relocation/restart state with combinational ROM/DRAM/RS decode.
// Optional feature macro ROM_SHADOW_WRITE_EN routes memory writes aimed at ROM areas to DRAM.
module mem_map_seq #(
    parameter int          ADDR_W      = 16,
    parameter int          PAGE_BITS   = 13,
    parameter int          N_ROM_BANKS = 2,
    parameter int          RS_BITS     = 10,
    parameter logic [15:0] RS_BASE_LO  = 16'h5800,
    parameter logic [15:0] RS_BASE_HI  = 16'hF800,
    parameter logic [7:0]  CFG_PORT    = 8'hF7,
    parameter int          IAH_BITS    = 10,
    parameter int          IAH_FETCHES = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [ADDR_W-1:0]      A,
    input  logic [7:0]             D,
    input  logic                   nMREQ,
    input  logic                   nIORQ,
    input  logic                   nWR,
    input  logic                   nM1,
    input  logic                   RESTART,
    output logic [N_ROM_BANKS-1:0] nROM,
    output logic                   nROMB,
    output logic                   nRS,
    output logic                   nDR,
    output logic                   nIAH,
    output logic                   BOOT,
    output logic                   RELOK
);

    localparam int BANK_W = (N_ROM_BANKS > 1) ? $clog2(N_ROM_BANKS) : 1;
    localparam int CNT_W  = (IAH_FETCHES > 1) ? $clog2(IAH_FETCHES) : 1;
    localparam logic [ADDR_W-1:0] RS_LO = ADDR_W'(RS_BASE_LO);
    localparam logic [ADDR_W-1:0] RS_HI = ADDR_W'(RS_BASE_HI);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_RST_SEQ} state_t;

    state_t              state_q, state_d;
    logic [BANK_W-1:0]   bank_q, bank_d;
    logic                relok_q, relok_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                io_q, m1_q;

    logic ioWr, cfgEvt, m1, m1Evt, inIahWin, p0, p1, shadowWr;
    logic [N_ROM_BANKS-1:0] romSel;
    logic rombSel;
    logic unused_d;

    assign unused_d = ^D;

    assign ioWr     = !nIORQ && !nWR && (A[7:0] == CFG_PORT);
    assign cfgEvt   = ioWr && !io_q;
    assign m1       = !nM1 && !nMREQ;
    assign m1Evt    = m1 && !m1_q;
    assign inIahWin = (A >> IAH_BITS) == '0;
    assign p0       = (A >> PAGE_BITS) == '0;
    assign p1       = (A >> PAGE_BITS) == ADDR_W'(1);

`ifdef ROM_SHADOW_WRITE_EN
    assign shadowWr = !nMREQ && !nWR;
`else
    assign shadowWr = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_BOOT;
            bank_q  <= '0;
            relok_q <= 1'b0;
            cnt_q   <= '0;
            io_q    <= 1'b0;
            m1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            relok_q <= relok_d;
            cnt_q   <= cnt_d;
            io_q    <= ioWr;
            m1_q    <= m1;
        end
    end

    // Config capture and mode transitions are independent, so both can land on the same edge.
    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        relok_d = relok_q;
        cnt_d   = cnt_q;
        if (cfgEvt) begin
            bank_d  = D[BANK_W-1:0];
            relok_d = D[6];
        end
        case (state_q)
            ST_BOOT: begin
                if (cfgEvt && D[7]) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (RESTART) begin
                    state_d = ST_RST_SEQ;
                    cnt_d   = '0;
                end
            end
            ST_RST_SEQ: begin
                if (m1Evt) begin
                    if (!inIahWin || cnt_q == CNT_W'(IAH_FETCHES - 1)) state_d = ST_RUN;
                    else cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // In BOOT the top page-1 bank is forced; a relocated non-zero bank hands page 0 to DRAM.
    always_comb begin
        romSel  = '0;
        rombSel = (state_q == ST_BOOT) && p0;
        if (state_q == ST_BOOT) begin
            romSel[N_ROM_BANKS-1] = p1;
        end else begin
            romSel[0] = p0 && !(relok_q && bank_q != '0);
            for (int k = 0; k < N_ROM_BANKS; k++) begin
                if (p1 && bank_q == BANK_W'(k)) romSel[k] = 1'b1;
            end
        end
        if (shadowWr) begin
            romSel  = '0;
            rombSel = 1'b0;
        end
    end

    assign nROM  = ~romSel;
    assign nROMB = !rombSel;
    assign nDR   = (romSel != '0) || rombSel;
    assign nRS   = !((A >> RS_BITS) == ((relok_q ? RS_HI : RS_LO) >> RS_BITS));
    assign nIAH  = !((state_q == ST_RST_SEQ) && !nMREQ && inIahWin);
    assign BOOT  = (state_q == ST_BOOT);
    assign RELOK = relok_q;

endmodule

// File: tb/tb_mem_map_seq.sv
// Directed bench for mem_map_seq with default parameters (two ROM banks, three restart fetches).
// Shadow-write vectors run only when ROM_SHADOW_WRITE_EN is defined.
module tb_mem_map_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] A;
    logic [7:0]  D;
    logic        nMREQ, nIORQ, nWR, nM1, RESTART;
    logic [1:0]  nROM;
    logic        nROMB, nRS, nDR, nIAH, BOOT, RELOK;

    int vecCount = 0;
    int errCount = 0;

    mem_map_seq dut (
        .CLK(CLK), .RST(RST), .A(A), .D(D),
        .nMREQ(nMREQ), .nIORQ(nIORQ), .nWR(nWR), .nM1(nM1), .RESTART(RESTART),
        .nROM(nROM), .nROMB(nROMB), .nRS(nRS), .nDR(nDR), .nIAH(nIAH),
        .BOOT(BOOT), .RELOK(RELOK)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic mreqN, input logic iorqN,
                                 input logic wrN, input logic m1N, input logic [7:0] data);
        A = addr; nMREQ = mreqN; nIORQ = iorqN; nWR = wrN; nM1 = m1N; D = data;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        applyStimulus(16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    endtask

    task automatic ioWrite(input logic [7:0] data);
        applyStimulus(16'h00F7, 1'b1, 1'b0, 1'b0, 1'b1, data);
        tick();
        idle();
        tick();
    endtask

    task automatic fetch(input string tag, input logic [15:0] addr, input logic expIah);
        applyStimulus(addr, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput(tag, {31'd0, nIAH}, {31'd0, expIah});
        tick();
        idle();
        tick();
    endtask

    task automatic pulseRestart();
        RESTART = 1'b1;
        tick();
        RESTART = 1'b0;
    endtask

    initial begin
        RST = 1'b1; RESTART = 1'b0;
        idle();
        tick(); tick();
        RST = 1'b0;

        // Reset state and BOOT decode
        applyStimulus(16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        checkOutput("rst_nROMB", {31'd0, nROMB}, 32'd0);
        checkOutput("rst_nROM", {30'd0, nROM}, 32'h3);
        checkOutput("rst_nDR", {31'd0, nDR}, 32'd1);
        checkOutput("rst_nRS", {31'd0, nRS}, 32'd1);
        checkOutput("rst_nIAH", {31'd0, nIAH}, 32'd1);
        checkOutput("rst_BOOT", {31'd0, BOOT}, 32'd1);
        checkOutput("rst_RELOK", {31'd0, RELOK}, 32'd0);
        applyStimulus(16'h2000, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        checkOutput("boot_p1_nROM", {30'd0, nROM}, 32'h1);
        applyStimulus(16'h8000, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        checkOutput("boot_dram_nDR", {31'd0, nDR}, 32'd0);

        // Held I/O strobe: D changes after the first cycle but must not be recaptured
        applyStimulus(16'h00F7, 1'b1, 1'b0, 1'b0, 1'b1, 8'h80);
        tick();
        checkOutput("cfg_BOOT", {31'd0, BOOT}, 32'd0);
        D = 8'hC1;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("hold_RELOK", {31'd0, RELOK}, 32'd0);
        idle();
        tick();
        applyStimulus(16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        checkOutput("run_p0_nROM", {30'd0, nROM}, 32'h2);
        checkOutput("run_p0_nROMB", {31'd0, nROMB}, 32'd1);
        applyStimulus(16'h2000, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        checkOutput("run_p1_bank0", {30'd0, nROM}, 32'h2);
        applyStimulus(16'h5800, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        checkOutput("rs_lo_nRS", {31'd0, nRS}, 32'd0);

        // Relocation and bank 1
        ioWrite(8'hC1);
        checkOutput("reloc_RELOK", {31'd0, RELOK}, 32'd1);
        checkOutput("reloc_BOOT", {31'd0, BOOT}, 32'd0);
        applyStimulus(16'h5800, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        checkOutput("reloc_5800_nRS", {31'd0, nRS}, 32'd1);
        applyStimulus(16'hF9FF, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        checkOutput("reloc_F9FF_nRS", {31'd0, nRS}, 32'd0);
        applyStimulus(16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        checkOutput("reloc_p0_nDR", {31'd0, nDR}, 32'd0);
        checkOutput("reloc_p0_nROM", {30'd0, nROM}, 32'h3);
        applyStimulus(16'h2000, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        checkOutput("bank1_p1_nROM", {30'd0, nROM}, 32'h1);
        idle();

        // Full restart sequence
        pulseRestart();
        fetch("iah_f0", 16'h0000, 1'b0);
        fetch("iah_f1", 16'h0001, 1'b0);
        fetch("iah_f2", 16'h0002, 1'b0);
        fetch("iah_f3_run", 16'h0003, 1'b1);

        // Out-of-window fetch ends the sequence early
        pulseRestart();
        fetch("oow_f0", 16'h0000, 1'b0);
        fetch("oow_8000", 16'h8000, 1'b1);
        fetch("oow_after", 16'h0001, 1'b1);

        // Reset in the middle of a sequence
        pulseRestart();
        fetch("mid_f0", 16'h0000, 1'b0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        applyStimulus(16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        checkOutput("mid_rst_BOOT", {31'd0, BOOT}, 32'd1);
        checkOutput("mid_rst_RELOK", {31'd0, RELOK}, 32'd0);
        checkOutput("mid_rst_nROMB", {31'd0, nROMB}, 32'd0);
        checkOutput("mid_rst_nIAH", {31'd0, nIAH}, 32'd1);
        idle();
        ioWrite(8'h80);
        applyStimulus(16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        checkOutput("rerun_p0_nROM", {30'd0, nROM}, 32'h2);
        idle();
        pulseRestart();
        fetch("re_f0", 16'h0000, 1'b0);
        fetch("re_f1", 16'h0001, 1'b0);
        fetch("re_f2", 16'h0002, 1'b0);
        fetch("re_f3", 16'h0003, 1'b1);

`ifdef ROM_SHADOW_WRITE_EN
        applyStimulus(16'h0100, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        checkOutput("shadow_wr_nROM", {30'd0, nROM}, 32'h3);
        checkOutput("shadow_wr_nDR", {31'd0, nDR}, 32'd0);
        applyStimulus(16'h0100, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        checkOutput("shadow_rd_nROM", {30'd0, nROM}, 32'h2);
`else
        applyStimulus(16'h0100, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        checkOutput("wr_rom_nROM", {30'd0, nROM}, 32'h2);
        checkOutput("wr_rom_nDR", {31'd0, nDR}, 32'd1);
`endif
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
